// File: rtl/rca_serial_seq.sv
// Serial wide adder: one 4-bit ripple-carry slice per clock, carry held between slices.
// Optional signed-overflow output enabled with `define RCA_SEQ_OVF_EN.

module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] sum,
  output logic       final_carry
);
  logic [4:0] carry;

  assign carry[0] = c;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign final_carry = carry[4];
endmodule

module rca_serial_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy,
  output logic                 ovf
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES + 1);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic [W-1:0]  sum_next;
  logic          carry_reg;
  logic          cout_reg;
  logic [IW-1:0] idx_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;
  logic          busy_reg;

  logic [3:0]    slice_a;
  logic [3:0]    slice_b;
  logic [3:0]    rca_sum;
  logic          rca_carry;

  assign slice_a = a_reg[{idx_reg, 2'b00} +: 4];
  assign slice_b = b_reg[{idx_reg, 2'b00} +: 4];

  rca4 u_rca (
    .a           (slice_a),
    .b           (slice_b),
    .c           (carry_reg),
    .sum         (rca_sum),
    .final_carry (rca_carry)
  );

  // Only the nibble addressed by the slice index picks up the adder result.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_sum
      assign sum_next[gi*4 +: 4] = (idx_reg == IW'(gi)) ? rca_sum : sum_reg[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      cout_reg      <= 1'b0;
      idx_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= a;
            b_reg        <= b;
            carry_reg    <= cin;
            idx_reg      <= '0;
            sum_reg      <= '0;
            cout_reg     <= 1'b0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= rca_carry;
          idx_reg   <= idx_reg + 1'b1;
          if (idx_reg == LAST) begin
            cout_reg      <= rca_carry;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

`ifdef RCA_SEQ_OVF_EN
  logic ovf_reg;

  // Same-sign operands whose result sign differs: evaluated with the final slice's MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == IDLE && in_valid) begin
      ovf_reg <= 1'b0;
    end else if (state_reg == RUN && idx_reg == LAST) begin
      ovf_reg <= (a_reg[W-1] ~^ b_reg[W-1]) & (rca_sum[3] ^ a_reg[W-1]);
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;
endmodule

// File: tb/tb_rca_serial_seq.sv
// Directed bench for rca_serial_seq: a 4-slice instance and a 1-slice instance on one clock.

module tb_rca_serial_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0, in_ready, cin = 1'b0, out_valid, out_ready = 1'b0;
  logic [15:0] a = '0, b = '0, sum;
  logic        cout, busy, ovf;

  logic        in_valid1 = 1'b0, in_ready1, cin1 = 1'b0, out_valid1, out_ready1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0, sum1;
  logic        cout1, busy1, ovf1;

  int checks_total  = 0;
  int checks_passed = 0;
  int lat;

`ifdef RCA_SEQ_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  rca_serial_seq #(.NIBBLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy), .ovf(ovf)
  );

  rca_serial_seq #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .busy(busy1), .ovf(ovf1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      checks_passed++;
  endtask

  // Accept one operand pair, then wait (bounded) for out_valid; leaves the DUT in DONE.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    @(negedge clk);
    check("accept_ready", in_ready, 1'b1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d ovf=%0d lat=%0d",
             ta, tb, tc, sum, cout, ovf, lat);
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("rel_out_valid", out_valid, 1'b0);
    check("rel_in_ready", in_ready, 1'b1);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", sum, 16'h0000);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: basic add, latency NIBBLES
    run_op(16'h1234, 16'h4321, 1'b0);
    check("t1_lat", lat, 4);
    check("t1_sum", sum, 16'h5555);
    check("t1_cout", cout, 1'b0);
    check("t1_busy", busy, 1'b1);
    release_out();

    // 2: carry ripples through every slice
    run_op(16'hFFFF, 16'h0001, 1'b0);
    check("t2_sum", sum, 16'h0000);
    check("t2_cout", cout, 1'b1);
    release_out();

    // 3: signed overflow cases
    run_op(16'h7FFF, 16'h0001, 1'b0);
    check("t3a_sum", sum, 16'h8000);
    check("t3a_cout", cout, 1'b0);
    check("t3a_ovf", ovf, OVF_ON);
    release_out();
    run_op(16'hFFFF, 16'hFFFF, 1'b1);
    check("t3b_sum", sum, 16'hFFFF);
    check("t3b_cout", cout, 1'b1);
    check("t3b_ovf", ovf, 1'b0);
    release_out();

    // 4: back-pressure in DONE with new operands offered
    run_op(16'h0F0F, 16'h0101, 1'b0);
    check("t4_sum0", sum, 16'h1010);
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_sum", sum, 16'h1010);
      check("t4_hold_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("t4_idle_ready", in_ready, 1'b1);
    check("t4_idle_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t4_accept_busy", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op a=1111 b=2222 cin=0 -> sum=%04h cout=%0d lat=%0d", sum, cout, lat);
    check("t4_lat", lat, 4);
    check("t4_sum", sum, 16'h3333);
    release_out();

    // 5: asynchronous reset mid-RUN at slice index 2
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_sum", sum, 16'h0000);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_ready", in_ready, 1'b1);
    check("t5_rst_valid", out_valid, 1'b0);
    check("t5_rst_cout", cout, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h00FF, 16'h0001, 1'b0);
    check("t5_sum", sum, 16'h0100);
    check("t5_cout", cout, 1'b0);
    release_out();

    // 6: single-slice instance
    @(negedge clk);
    check("t6_ready", in_ready1, 1'b1);
    a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    check("t6_valid_early", out_valid1, 1'b0);
    @(posedge clk); #1;
    $display("op1 a=9 b=8 cin=1 -> sum=%0h cout=%0d ovf=%0d", sum1, cout1, ovf1);
    check("t6_valid", out_valid1, 1'b1);
    check("t6_sum", sum1, 4'h2);
    check("t6_cout", cout1, 1'b1);
    check("t6_ovf", ovf1, OVF_ON);
    @(negedge clk);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("t6_idle", in_ready1, 1'b1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end
endmodule
